// File: rtl/csa_sbox_if.sv
// Handshake bundle for csa_sbox_engine: input transaction, result stream,
// flush and completed-block counter.
interface csa_sbox_if #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [36*LANES-1:0]   a_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [14*LANES-1:0]   out_s;
    logic [CNT_W-1:0]      blk_cnt;

    modport master (
        output flush, in_valid, a_in, out_ready,
        input  in_ready, out_valid, out_s, blk_cnt
    );

    modport slave (
        input  flush, in_valid, a_in, out_ready,
        output in_ready, out_valid, out_s, blk_cnt
    );
endinterface

// File: rtl/csa_sbox_engine.sv
// DVB-CSA stream-cipher S-box engine: evaluates s1..s7 for LANES 36-bit A
// states per transaction, either all lanes at once or through one shared bank.
module csa_sbox_engine #(
    parameter int LANES  = 4,
    parameter int SERIAL = 0,
    parameter int CNT_W  = 16
) (
    input  logic       clk,
    input  logic       rst,
    csa_sbox_if.slave  bus
);
    localparam int AW  = 36 * LANES;
    localparam int SW  = 14 * LANES;
    localparam int LCW = (LANES > 1) ? $clog2(LANES) : 1;

    // Stream-cipher S-box tables, entry 0 first.
    localparam int SB [7][32] = '{
        '{2,0,1,1,2,3,3,0, 3,2,2,0,1,1,0,3, 0,3,3,0,2,2,1,1, 2,2,0,3,1,1,3,0},
        '{3,1,0,2,2,3,3,0, 1,3,2,1,0,0,1,2, 3,1,0,3,3,2,0,2, 0,0,1,2,2,1,3,1},
        '{2,0,1,2,2,3,3,1, 1,1,0,3,3,0,2,0, 1,3,0,1,3,0,2,2, 2,0,1,2,0,3,3,1},
        '{3,1,2,3,0,2,1,2, 1,2,0,1,3,0,0,3, 1,0,3,1,2,3,0,3, 0,3,2,0,1,2,2,1},
        '{2,0,0,1,3,2,3,2, 0,1,3,3,1,0,2,1, 2,3,2,0,0,3,1,1, 1,0,3,2,3,1,0,2},
        '{0,1,2,3,1,2,2,0, 0,1,3,0,2,3,1,3, 2,3,0,2,3,0,1,1, 2,1,1,2,0,3,3,0},
        '{0,3,2,2,3,0,0,1, 3,0,1,3,1,2,2,1, 1,0,3,3,0,1,1,2, 2,3,1,0,2,3,0,2}
    };

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic logic [1:0] lut(input int s, input logic [4:0] idx);
        return 2'(SB[s][idx]);
    endfunction

    // Nibble An of the A state sits at a[(n-1)*4 +: 4]; A1 bit 0 is unused.
    function automatic logic [13:0] sbox_bank(input logic [35:0] a);
        return {lut(6, {a[6],  a[8],  a[25], a[30], a[31]}),
                lut(5, {a[9],  a[13], a[16], a[26], a[35]}),
                lut(4, {a[18], a[15], a[20], a[29], a[34]}),
                lut(3, {a[11], a[1],  a[7],  a[14], a[28]}),
                lut(2, {a[3],  a[4],  a[17], a[19], a[22]}),
                lut(1, {a[5],  a[10], a[23], a[24], a[33]}),
                lut(0, {a[12], a[2],  a[21], a[27], a[32]})};
    endfunction

    state_t           state;
    logic [AW-1:0]    a_reg;
    logic [SW-1:0]    out_s_reg;
    logic [SW-1:0]    calc_s;
    logic [CNT_W-1:0] blk_cnt_reg;
    logic [LCW-1:0]   lane_cnt;
    logic             out_valid_reg;
    logic             in_ready;
    logic             accept;
    logic             last_lane;

    assign in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign last_lane = (SERIAL == 0) || (lane_cnt == LCW'(LANES - 1));

    if (SERIAL == 0) begin : g_par
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        always_comb begin
            calc_s = '0;
            for (int i = 0; i < LANES; i++)
                calc_s[i*14 +: 14] = sbox_bank(a_reg[i*36 +: 36]);
        end
    end else begin : g_ser
        // Only the current lane's slot changes; earlier slots are carried through.
        always_comb begin
            calc_s = out_s_reg;
            calc_s[int'(lane_cnt)*14 +: 14] = sbox_bank(a_reg[int'(lane_cnt)*36 +: 36]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the A register is a plain pipeline register, so it is
            // reset along with the rest rather than left as uninitialised storage.
            state         <= IDLE;
            a_reg         <= '0;
            out_s_reg     <= '0;
            out_valid_reg <= 1'b0;
            blk_cnt_reg   <= '0;
            lane_cnt      <= '0;
        end else if (bus.flush) begin
            state         <= IDLE;
            out_valid_reg <= 1'b0;
            lane_cnt      <= '0;
        end else begin
            if (state == DONE && bus.out_ready)
                blk_cnt_reg <= blk_cnt_reg + CNT_W'(1);
            case (state)
                IDLE: ;
                CALC: begin
                    out_s_reg <= calc_s;
                    if (last_lane) begin
                        state         <= DONE;
                        out_valid_reg <= 1'b1;
                        lane_cnt      <= '0;
                    end else begin
                        lane_cnt <= lane_cnt + LCW'(1);
                    end
                end
                DONE: if (bus.out_ready) begin
                    state         <= IDLE;
                    out_valid_reg <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            // Acceptance overrides the DONE->IDLE exit for back-to-back blocks.
            if (accept) begin
                a_reg         <= bus.a_in;
                lane_cnt      <= '0;
                state         <= CALC;
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_s     = out_s_reg;
    assign bus.blk_cnt   = blk_cnt_reg;
endmodule
